// File: rtl/stark_branchmiss_ctrl_pkg.sv
// Shared types for the branch-miss collector: branch-target source encoding,
// FSM states and the modular sequence-age comparison.
package stark_branchmiss_ctrl_pkg;

    typedef enum logic [2:0] {
        BTS_NONE = 3'd0,
        BTS_REG  = 3'd1,
        BTS_DISP = 3'd2,
        BTS_CALL = 3'd3,
        BTS_RET  = 3'd4,
        BTS_IMM  = 3'd5
    } bts_t;

    typedef enum logic [1:0] {
        BM_IDLE   = 2'd0,
        BM_PEND   = 2'd1,
        BM_SHADOW = 2'd2
    } bm_state_t;

    localparam int SEQ_MAX_BITS = 31;

    // a is older than b when (a - b) mod 2**bits is negative; bits must be 1..31.
    function automatic logic seq_older(input logic [31:0] a, input logic [31:0] b,
                                       input int unsigned bits);
        logic [31:0] d;
        d = (a - b) << (32 - bits);
        return d[31];
    endfunction

endpackage

// File: rtl/stark_oldest_sel.sv
// Combinational N-way oldest-tag selector; ties resolve to the lowest index.
module stark_oldest_sel
    import stark_branchmiss_ctrl_pkg::*;
#(
    parameter int N  = 2,
    parameter int TW = 6,
    parameter int IW = 1
) (
    input  logic [N-1:0]         cand,
    input  logic [N-1:0][TW-1:0] tag,
    output logic                 win_valid,
    output logic [IW-1:0]        win_idx
);

    logic [TW-1:0] best_tag;

    // Only a strictly older tag displaces the current pick, so equal tags keep the lower index.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        best_tag  = '0;
        for (int c = 0; c < N; c++) begin
            if (cand[c] && (!win_valid ||
                            seq_older(32'(tag[c]), 32'(best_tag), TW))) begin
                win_valid = 1'b1;
                win_idx   = IW'(c);
                best_tag  = tag[c];
            end
        end
    end

endmodule

// File: rtl/stark_branchmiss_ctrl.sv
// Collects branch resolves from NCH units, reports the oldest mispredict as a
// pulse or a held flag, and filters stale younger resolves after each flush.
module stark_branchmiss_ctrl
    import stark_branchmiss_ctrl_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int SEQ_BITS   = 6,
    parameter int AWID       = 32,
    parameter int MODE       = 1,
    parameter int SHADOW_CYC = 4,
    parameter int CNT_BITS   = 16,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCH-1:0]                trig,
    input  bts_t [NCH-1:0]                bts,
    input  logic [NCH-1:0]                miss_det,
    input  logic [NCH-1:0][SEQ_BITS-1:0]  tag,
    input  logic [NCH-1:0][AWID-1:0]      tgt,
    input  logic                          miss_ack,
    output logic                          miss_flag,
    output logic [SEQ_BITS-1:0]           miss_tag,
    output logic [AWID-1:0]               miss_tgt,
    output logic [CH_W-1:0]               miss_ch,
    output logic [CNT_BITS-1:0]           miss_cnt
);

    localparam int SH_W = (SHADOW_CYC > 0) ? $clog2(SHADOW_CYC + 1) : 1;
    localparam logic [SH_W-1:0] SH_LOAD = SH_W'(SHADOW_CYC);

    logic [NCH-1:0]      cand_p0;
    logic                win_valid_p0;
    logic [CH_W-1:0]     win_idx_p0;
    logic [SEQ_BITS-1:0] win_tag_p0;
    logic [AWID-1:0]     win_tgt_p0;
    logic                win_older_p0;
    logic                take_p0;

    bm_state_t           state_q, state_n;
    logic [SH_W-1:0]     sh_q, sh_n;
    logic                vld_p1, vld_n;
    logic [SEQ_BITS-1:0] tag_p1, tag_n;
    logic [AWID-1:0]     tgt_p1, tgt_n;
    logic [CH_W-1:0]     ch_p1, ch_n;
    logic [CNT_BITS-1:0] cnt_p1, cnt_n;

    // ---- stage p0: candidate qualification and oldest selection ----
    always_comb begin
        cand_p0 = '0;
        for (int c = 0; c < NCH; c++) begin
            case (bts[c])
                BTS_REG, BTS_DISP: cand_p0[c] = trig[c] & miss_det[c];
                BTS_CALL, BTS_RET: cand_p0[c] = trig[c];
                default:           cand_p0[c] = 1'b0;
            endcase
        end
    end

    stark_oldest_sel #(
        .N  (NCH),
        .TW (SEQ_BITS),
        .IW (CH_W)
    ) u_sel (
        .cand      (cand_p0),
        .tag       (tag),
        .win_valid (win_valid_p0),
        .win_idx   (win_idx_p0)
    );

    assign win_tag_p0   = tag[win_idx_p0];
    assign win_tgt_p0   = tgt[win_idx_p0];
    assign win_older_p0 = seq_older(32'(win_tag_p0), 32'(tag_p1), SEQ_BITS);

    always_comb begin
        state_n = state_q;
        sh_n    = sh_q;
        vld_n   = 1'b0;
        tag_n   = tag_p1;
        tgt_n   = tgt_p1;
        ch_n    = ch_p1;
        cnt_n   = cnt_p1;
        take_p0 = 1'b0;

        case (state_q)
            BM_IDLE: take_p0 = win_valid_p0;
            BM_PEND: begin
                vld_n = 1'b1;
                // An older preempting miss outranks the ack, which stays pending.
                if (win_valid_p0 && win_older_p0) begin
                    take_p0 = 1'b1;
                end else if (miss_ack) begin
                    vld_n = 1'b0;
                    if (SHADOW_CYC == 0) begin
                        state_n = BM_IDLE;
                    end else begin
                        state_n = BM_SHADOW;
                        sh_n    = SH_LOAD;
                    end
                end
            end
            BM_SHADOW: begin
                if (win_valid_p0 && win_older_p0) begin
                    take_p0 = 1'b1;
                end else if (sh_q <= SH_W'(1)) begin
                    state_n = BM_IDLE;
                    sh_n    = '0;
                end else begin
                    sh_n = sh_q - SH_W'(1);
                end
            end
            default: begin
                state_n = BM_IDLE;
                sh_n    = '0;
            end
        endcase

        if (take_p0) begin
            vld_n = 1'b1;
            tag_n = win_tag_p0;
            tgt_n = win_tgt_p0;
            ch_n  = win_idx_p0;
            if (cnt_p1 != '1) begin
                cnt_n = cnt_p1 + CNT_BITS'(1);
            end
            if (MODE != 0) begin
                state_n = BM_PEND;
            end else if (SHADOW_CYC == 0) begin
                state_n = BM_IDLE;
                sh_n    = '0;
            end else begin
                state_n = BM_SHADOW;
                sh_n    = SH_LOAD;
            end
        end
    end

    // ---- stage p1: registered miss report ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BM_IDLE;
            sh_q    <= '0;
            vld_p1  <= 1'b0;
            tag_p1  <= '0;
            tgt_p1  <= '0;
            ch_p1   <= '0;
            cnt_p1  <= '0;
        end else begin
            state_q <= state_n;
            sh_q    <= sh_n;
            vld_p1  <= vld_n;
            tag_p1  <= tag_n;
            tgt_p1  <= tgt_n;
            ch_p1   <= ch_n;
            cnt_p1  <= cnt_n;
        end
    end

    assign miss_flag = vld_p1;
    assign miss_tag  = tag_p1;
    assign miss_tgt  = tgt_p1;
    assign miss_ch   = ch_p1;
    assign miss_cnt  = cnt_p1;

endmodule

// File: tb/tb_stark_branchmiss_ctrl.sv
// Bench for stark_branchmiss_ctrl: a held-flag and a pulse instance share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_stark_branchmiss_ctrl;
    import stark_branchmiss_ctrl_pkg::*;

    localparam int SC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        trig;
    bts_t [1:0]        bts;
    logic [1:0]        miss_det;
    logic [1:0][5:0]   tag;
    logic [1:0][31:0]  tgt;
    logic              miss_ack;

    logic        dp_flag, dz_flag;
    logic [5:0]  dp_tag, dz_tag;
    logic [31:0] dp_tgt, dz_tgt;
    logic [0:0]  dp_ch, dz_ch;
    logic [15:0] dp_cnt;
    logic [2:0]  dz_cnt;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    // model state, index 0 = held-flag instance, 1 = pulse instance
    localparam int PH_IDLE = 0, PH_PEND = 1, PH_SHADOW = 2;
    longint m_flag[2], m_tag[2], m_tgt[2], m_ch[2], m_cnt[2];
    int     m_ph[2], m_sh[2];

    always #5 clk = ~clk;

    stark_branchmiss_ctrl #(
        .NCH(2), .SEQ_BITS(6), .AWID(32), .MODE(1), .SHADOW_CYC(SC), .CNT_BITS(16)
    ) dp (
        .clk(clk), .rst(rst), .trig(trig), .bts(bts), .miss_det(miss_det),
        .tag(tag), .tgt(tgt), .miss_ack(miss_ack), .miss_flag(dp_flag),
        .miss_tag(dp_tag), .miss_tgt(dp_tgt), .miss_ch(dp_ch), .miss_cnt(dp_cnt)
    );

    stark_branchmiss_ctrl #(
        .NCH(2), .SEQ_BITS(6), .AWID(32), .MODE(0), .SHADOW_CYC(SC), .CNT_BITS(3)
    ) dz (
        .clk(clk), .rst(rst), .trig(trig), .bts(bts), .miss_det(miss_det),
        .tag(tag), .tgt(tgt), .miss_ack(miss_ack), .miss_flag(dz_flag),
        .miss_tag(dz_tag), .miss_tgt(dz_tgt), .miss_ch(dz_ch), .miss_cnt(dz_cnt)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit older(input int a, input int b);
        return ((a - b) & 63) >= 32;
    endfunction

    function automatic bit is_cand(input int c);
        case (bts[c])
            BTS_REG, BTS_DISP: return trig[c] && miss_det[c];
            BTS_CALL, BTS_RET: return trig[c];
            default:           return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_flag[m] = 0; m_tag[m] = 0; m_tgt[m] = 0; m_ch[m] = 0; m_cnt[m] = 0;
            m_ph[m] = PH_IDLE; m_sh[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input bit wv, input int wc, input int wt,
                              input longint wg);
        bit take;
        longint cmax;
        cmax = (m == 0) ? 65535 : 7;
        take = (m_ph[m] == PH_IDLE) ? wv : (wv && older(wt, int'(m_tag[m])));
        if (take) begin
            m_flag[m] = 1; m_tag[m] = wt; m_tgt[m] = wg; m_ch[m] = wc;
            if (m_cnt[m] < cmax) m_cnt[m]++;
            if (m == 0) m_ph[m] = PH_PEND;
            else begin m_ph[m] = PH_SHADOW; m_sh[m] = SC; end
        end else if (m_ph[m] == PH_PEND) begin
            if (miss_ack) begin m_flag[m] = 0; m_ph[m] = PH_SHADOW; m_sh[m] = SC; end
        end else begin
            m_flag[m] = 0;
            if (m_ph[m] == PH_SHADOW) begin
                if (m_sh[m] <= 1) begin m_ph[m] = PH_IDLE; m_sh[m] = 0; end
                else m_sh[m]--;
            end
        end
    endtask

    // model advances on the same edges as the DUT, using the inputs driven at negedge
    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else begin
            bit c0, c1, wv;
            int wc;
            c0 = is_cand(0);
            c1 = is_cand(1);
            wv = c0 | c1;
            if (c0 && c1) wc = older(int'(tag[1]), int'(tag[0])) ? 1 : 0;
            else wc = c1 ? 1 : 0;
            for (int m = 0; m < 2; m++)
                model_step(m, wv, wc, int'(tag[wc]), longint'(tgt[wc]));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("dp_flag", longint'(dp_flag), m_flag[0]);
            check("dp_tag",  longint'(dp_tag),  m_tag[0]);
            check("dp_tgt",  longint'(dp_tgt),  m_tgt[0]);
            check("dp_ch",   longint'(dp_ch),   m_ch[0]);
            check("dp_cnt",  longint'(dp_cnt),  m_cnt[0]);
            check("dz_flag", longint'(dz_flag), m_flag[1]);
            check("dz_tag",  longint'(dz_tag),  m_tag[1]);
            check("dz_tgt",  longint'(dz_tgt),  m_tgt[1]);
            check("dz_ch",   longint'(dz_ch),   m_ch[1]);
            check("dz_cnt",  longint'(dz_cnt),  m_cnt[1]);
        end
    end

    task automatic clr_in();
        trig = '0; miss_det = '0; miss_ack = 1'b0;
        bts[0] = BTS_NONE; bts[1] = BTS_NONE;
        tag = '0; tgt = '0;
    endtask

    task automatic drv(input int c, input bts_t b, input bit d, input int t,
                       input logic [31:0] g);
        trig[c] = 1'b1; bts[c] = b; miss_det[c] = d; tag[c] = 6'(t); tgt[c] = g;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_and_settle();
        miss_ack = 1'b1;
        cyc(1);
        clr_in();
        check("dp_flag_after_ack", longint'(dp_flag), 0);
        cyc(8);
    endtask

    initial begin
        rst = 1'b0;
        clr_in();
        cyc(2);
        cmp_en = 1'b1;
        check("rst_dp_flag", longint'(dp_flag), 0);
        check("rst_dp_cnt",  longint'(dp_cnt), 0);
        check("rst_dz_tgt",  longint'(dz_tgt), 0);
        rst = 1'b1;
        cyc(2);

        // single DISP miss
        drv(0, BTS_DISP, 1, 5, 32'h1000);
        cyc(1); clr_in();
        check("t1_flag", longint'(dp_flag), 1);
        check("t1_tag",  longint'(dp_tag), 5);
        check("t1_tgt",  longint'(dp_tgt), 32'h1000);
        check("t1_ch",   longint'(dp_ch), 0);
        check("t1_cnt",  longint'(dp_cnt), 1);
        check("t1_pulse_hi", longint'(dz_flag), 1);
        cyc(1);
        check("t1_held", longint'(dp_flag), 1);
        check("t1_pulse_lo", longint'(dz_flag), 0);
        ack_and_settle();

        // same-cycle pair, ch1 older
        drv(0, BTS_REG, 1, 9, 32'h2000);
        drv(1, BTS_REG, 1, 7, 32'h3000);
        cyc(1); clr_in();
        check("t2_ch",  longint'(dp_ch), 1);
        check("t2_tag", longint'(dp_tag), 7);
        check("t2_tgt", longint'(dp_tgt), 32'h3000);
        ack_and_settle();

        // wrap-around age
        drv(0, BTS_DISP, 1, 62, 32'h4000);
        drv(1, BTS_DISP, 1, 1, 32'h5000);
        cyc(1); clr_in();
        check("t3_tag", longint'(dp_tag), 62);
        check("t3_ch",  longint'(dp_ch), 0);
        ack_and_settle();

        // preempt and ignore in PEND, then shadow filtering
        drv(0, BTS_CALL, 0, 20, 32'h6000);
        cyc(1); clr_in();
        check("t4_tag20", longint'(dp_tag), 20);
        drv(1, BTS_REG, 1, 18, 32'h7000);
        cyc(1); clr_in();
        check("t4_tag18", longint'(dp_tag), 18);
        check("t4_cnt5",  longint'(dp_cnt), 5);
        drv(0, BTS_REG, 1, 25, 32'h8000);
        cyc(1); clr_in();
        check("t4_ign_flag", longint'(dp_flag), 1);
        check("t4_ign_tag",  longint'(dp_tag), 18);
        miss_ack = 1'b1;
        cyc(1); clr_in();
        check("t4_ack_flag", longint'(dp_flag), 0);
        cyc(1);
        drv(0, BTS_DISP, 1, 30, 32'h9000);
        cyc(1); clr_in();
        check("t4_drop_flag", longint'(dp_flag), 0);
        check("t4_drop_tag",  longint'(dp_tag), 18);
        drv(0, BTS_DISP, 1, 10, 32'hA000);
        cyc(1); clr_in();
        check("t4_acc_flag", longint'(dp_flag), 1);
        check("t4_acc_tag",  longint'(dp_tag), 10);
        check("t4_cnt6",     longint'(dp_cnt), 6);
        ack_and_settle();

        // non-candidates
        drv(0, BTS_NONE, 1, 40, 32'hB000);
        drv(1, BTS_IMM, 1, 41, 32'hC000);
        cyc(1); clr_in();
        check("noncand_flag", longint'(dp_flag), 0);

        // pulse instance RET, then async reset mid-shadow
        cyc(4);
        drv(1, BTS_RET, 0, 3, 32'hD000);
        cyc(1); clr_in();
        check("ret_pulse_hi", longint'(dz_flag), 1);
        check("ret_pulse_tag", longint'(dz_tag), 3);
        cyc(1);
        check("ret_pulse_lo", longint'(dz_flag), 0);
        #2 rst = 1'b0;
        #1;
        check("arst_dz_flag", longint'(dz_flag), 0);
        check("arst_dz_tag",  longint'(dz_tag), 0);
        check("arst_dz_cnt",  longint'(dz_cnt), 0);
        check("arst_dp_flag", longint'(dp_flag), 0);
        check("arst_dp_tgt",  longint'(dp_tgt), 0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        drv(0, BTS_REG, 0, 12, 32'hE000);
        cyc(1); clr_in();
        check("reg_nodet_dp", longint'(dp_flag), 0);
        check("reg_nodet_dz", longint'(dz_flag), 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            trig     = 2'($urandom_range(0, 3));
            miss_det = 2'($urandom_range(0, 3));
            for (int c = 0; c < 2; c++) begin
                bts[c] = bts_t'(3'($urandom_range(0, 7)));
                tag[c] = 6'($urandom_range(0, 63));
                tgt[c] = $urandom;
            end
            miss_ack = ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        clr_in();
        cyc(SC + 2);
        check("dz_cnt_sat", longint'(dz_cnt), 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
